// File: rtl/demux8_reg.sv
// demux8_reg: registered 1-to-8 demultiplexer with valid/ready handshakes.
// It fans the single result bus out to eight one-entry channel holding registers.
// Optional feature: define DEMUX8_BCAST_EN to add the BCAST port. When BCAST=1,
// one word is written into every channel at once.
// Ports:
//   CLK, RST (async, active-high)
//   IN/SEL/IN_VALID -> IN_READY   producer side (IN_READY is combinational)
//   OUT/OUT_VALID   <- OUT_READY  eight consumer channels; channel i sits at
//                                 OUT[i*DATA_WIDTH +: DATA_WIDTH]
//   BUSY                          OR of OUT_VALID
//   BCAST                         broadcast request (DEMUX8_BCAST_EN only)
// Latency: an accept at edge N makes the word visible in cycle N+1.
// A channel that drains and loads in the same cycle stays valid, so it has no bubble.
module demux8_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   IN,
    input  logic [2:0]              SEL,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [8*DATA_WIDTH-1:0] OUT,
    output logic [7:0]              OUT_VALID,
    input  logic [7:0]              OUT_READY,
`ifdef DEMUX8_BCAST_EN
    input  logic                    BCAST,
`endif
    output logic                    BUSY
);

    logic [DATA_WIDTH-1:0] data_reg [8];
    logic [7:0]            vld_reg;
    logic [7:0]            free;
    logic [7:0]            load;
    logic                  accept;
    logic                  bcast_req;

`ifdef DEMUX8_BCAST_EN
    assign bcast_req = BCAST;
`else
    assign bcast_req = 1'b0;
`endif

    // A channel can take a new word if it is empty or is being drained this cycle.
    assign free = ~vld_reg | OUT_READY;

    always_comb begin
        IN_READY = free[SEL];
        load     = 8'h01 << SEL;
        if (bcast_req) begin
            IN_READY = &free;
            load     = 8'hFF;
        end
    end

    // Reset is asynchronous, but gating with RST keeps the accept definition honest.
    assign accept = IN_VALID && IN_READY && !RST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_reg <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (accept && load[i]) begin
                    data_reg[i] <= IN;
                    vld_reg[i]  <= 1'b1;
                end else if (OUT_READY[i]) begin
                    vld_reg[i]  <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_out
        assign OUT[g*DATA_WIDTH +: DATA_WIDTH] = data_reg[g];
    end

    assign OUT_VALID = vld_reg;
    assign BUSY      = |vld_reg;

endmodule

// File: tb/tb_demux8_reg.sv
// tb_demux8_reg: self-checking bench for demux8_reg.
// A negedge monitor keeps one expected-word queue per channel. It pushes on
// accepts and pops on drains, and it compares every output against that model.
module tb_demux8_reg;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] in_w = '0;
    logic [2:0]    sel = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [8*DW-1:0] out_w;
    logic [7:0]    out_valid;
    logic [7:0]    out_ready = '0;
    logic          busy;
    logic          bcast = 1'b0;

    demux8_reg #(.DATA_WIDTH(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN        (in_w),
        .SEL       (sel),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OUT       (out_w),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
`ifdef DEMUX8_BCAST_EN
        .BCAST     (bcast),
`endif
        .BUSY      (busy)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int accepts  = 0;
    int drains   = 0;
    logic [DW-1:0] exp_q [8][$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) exp_q[i].delete();
    endtask

    // The model's view of occupancy and readiness is derived from the queues, not from the DUT.
    always @(negedge CLK) begin : monitor
        logic [7:0] mv;
        logic       mready;
        if (!RST) begin
            for (int i = 0; i < 8; i++) mv[i] = (exp_q[i].size() != 0);
            check("out_valid", 64'(out_valid), 64'(mv));
            check("busy", 64'(busy), 64'(|mv));
            for (int i = 0; i < 8; i++)
                if (mv[i]) check($sformatf("slice%0d", i), 64'(out_w[i*DW +: DW]), 64'(exp_q[i][0]));
            mready = bcast ? &(~mv | out_ready) : (~mv[sel] | out_ready[sel]);
            check("in_ready", 64'(in_ready), 64'(mready));
            for (int i = 0; i < 8; i++)
                if (mv[i] && out_ready[i]) begin
                    void'(exp_q[i].pop_front());
                    drains++;
                end
            if (in_valid && mready) begin
                accepts++;
                if (bcast) begin
                    for (int i = 0; i < 8; i++) exp_q[i].push_back(in_w);
                end else begin
                    exp_q[sel].push_back(in_w);
                end
            end
        end
    end

    task automatic write1(input logic [2:0] s, input logic [DW-1:0] d);
        sel = s; in_w = d; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain_all();
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;
    endtask

    int base;

    initial begin
        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out", out_w, 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // Unicast and stall on a full channel
        write1(3'd3, 8'hA5);
        check("uni_valid", 64'(out_valid), 64'h08);
        check("uni_data", 64'(out_w[3*DW +: DW]), 64'hA5);
        sel = 3'd3; in_w = 8'h5A; in_valid = 1'b1;
        #1;
        check("uni_stall_rdy", 64'(in_ready), 64'h0);
        tick();
        tick();
        check("uni_still_old", 64'(out_w[3*DW +: DW]), 64'hA5);
        out_ready[3] = 1'b1;
        #1;
        check("uni_rdy_comb", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0; out_ready = 8'h00;
        check("uni_replace", 64'(out_w[3*DW +: DW]), 64'h5A);
        check("uni_replace_v", 64'(out_valid), 64'h08);
        drain_all();

        // Pass-through on channel 5
        out_ready = 8'h20;
        base = accepts;
        for (int k = 1; k <= 16; k++) begin
            sel = 3'd5; in_w = DW'(k); in_valid = 1'b1;
            #1;
            check("pt_rdy", 64'(in_ready), 64'h1);
            tick();
        end
        in_valid = 1'b0;
        check("pt_last", 64'(out_w[5*DW +: DW]), 64'h10);
        tick();
        out_ready = 8'h00;
        check("pt_accepts", 64'(accepts - base), 64'd16);

        // Independent channels drain together
        for (int i = 0; i < 8; i++) write1(3'(i), 8'h10 + 8'(i));
        check("ind_full", 64'(out_valid), 64'hFF);
        base = drains;
        drain_all();
        check("ind_empty", 64'(out_valid), 64'h00);
        check("ind_drains", 64'(drains - base), 64'd8);

        // Blocked select change
        write1(3'd2, 8'h22);
        sel = 3'd2; in_w = 8'h66; in_valid = 1'b1;
        #1;
        check("blk_stall", 64'(in_ready), 64'h0);
        tick();
        sel = 3'd6;
        #1;
        check("blk_switch_rdy", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check("blk_d6", 64'(out_w[6*DW +: DW]), 64'h66);
        check("blk_d2", 64'(out_w[2*DW +: DW]), 64'h22);
        drain_all();

`ifdef DEMUX8_BCAST_EN
        // Broadcast
        bcast = 1'b1;
        write1(3'd4, 8'h3C);
        check("bc_valid", 64'(out_valid), 64'hFF);
        check("bc_data", out_w, {8{8'h3C}});
        drain_all();
        bcast = 1'b0;
        write1(3'd1, 8'h11);
        bcast = 1'b1; in_w = 8'h77; in_valid = 1'b1;
        #1;
        check("bc_block_rdy", 64'(in_ready), 64'h0);
        tick();
        in_valid = 1'b0; bcast = 1'b0;
        check("bc_block_v", 64'(out_valid), 64'h02);
        check("bc_block_d", 64'(out_w[1*DW +: DW]), 64'h11);
        drain_all();
`endif

        // Asynchronous reset mid-cycle discards held words
        write1(3'd2, 8'hC2);
        write1(3'd5, 8'hC5);
        check("pre_rst_v", 64'(out_valid), 64'h24);
        #2;
        RST = 1'b1;
        #1;
        clear_model();
        check("arst_valid", 64'(out_valid), 64'h00);
        check("arst_out", out_w, 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_rdy", 64'(in_ready), 64'h1);
        sel = 3'd0; in_w = 8'hEE; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        RST = 1'b0;
        tick();
        check("post_rst_v", 64'(out_valid), 64'h00);
        check("post_rst_d0", 64'(out_w[0 +: DW]), 64'h00);

        // Random traffic checked by the monitor
        for (int c = 0; c < 300; c++) begin
            in_w = DW'($urandom);
            sel = 3'($urandom_range(0, 7));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 8'hFF;
        tick();
        tick();
        out_ready = 8'h00;
        begin
            int left;
            left = 0;
            for (int i = 0; i < 8; i++) left += exp_q[i].size();
            check("final_empty", 64'(left), 64'd0);
        end
        check("final_valid", 64'(out_valid), 64'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
